// File: rtl/netdma_mm_read_arbiter.sv
// Round-robin arbiter sharing one Avalon-MM pipelined read master between two requesters.
// An in-order ID FIFO remembers who issued each outstanding read so responses route back.
module netdma_mm_read_arbiter #(
   parameter int DATA_WIDTH  = 64,
   parameter int MAX_PENDING = 8
) (
   input  logic                              clk,
   input  logic                              rst_n,

   input  logic [31:0]                       req0_address,
   input  logic                              req0_read,
   output logic                              req0_waitrequest,
   output logic [DATA_WIDTH-1:0]             req0_readdata,
   output logic                              req0_readdatavalid,

   input  logic [31:0]                       req1_address,
   input  logic                              req1_read,
   output logic                              req1_waitrequest,
   output logic [DATA_WIDTH-1:0]             req1_readdata,
   output logic                              req1_readdatavalid,

   output logic [31:0]                       mm_address,
   output logic                              mm_read,
   input  logic                              mm_waitrequest,
   input  logic [DATA_WIDTH-1:0]             mm_readdata,
   input  logic                              mm_readdatavalid,

   output logic [$clog2(MAX_PENDING):0]      pending,
   output logic                              orphan_err
);

   localparam int PTR_W = $clog2(MAX_PENDING);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(MAX_PENDING);

   logic                 locked_reg;
   logic                 lock_id_reg;
   logic                 last_grant_reg;
   logic [CNT_W-1:0]     pending_reg;
   logic [PTR_W-1:0]     wr_ptr_reg;
   logic [PTR_W-1:0]     rd_ptr_reg;
   logic                 orphan_reg;
   logic                 id_mem [MAX_PENDING];

   logic                 grant;
   logic                 grant_read;
   logic                 full;
   logic                 empty;
   logic                 accept;
   logic                 stall;
   logic                 pop;
   logic                 head;

   logic [1:0]           req_read;
   logic [31:0]          req_address [2];
   logic [1:0]           req_waitrequest;
   logic [1:0]           req_readdatavalid;

   assign req_read       = {req1_read, req0_read};
   assign req_address[0] = req0_address;
   assign req_address[1] = req1_address;

   // A locked grant pins the stalled command; otherwise a tie goes to whoever did not win last.
   always_comb begin
      grant = 1'b0;
      if (locked_reg) begin
         grant = lock_id_reg;
      end else if (req0_read && !req1_read) begin
         grant = 1'b0;
      end else if (!req0_read && req1_read) begin
         grant = 1'b1;
      end else if (req0_read && req1_read) begin
         grant = ~last_grant_reg;
      end
   end

   assign full       = (pending_reg == CNT_FULL);
   assign empty      = (pending_reg == '0);
   assign grant_read = req_read[grant];
   assign mm_read    = grant_read && !full && rst_n;
   assign mm_address = req_address[grant];
   assign accept     = mm_read && !mm_waitrequest;
   assign stall      = mm_read && mm_waitrequest;

   assign head = id_mem[rd_ptr_reg];
   assign pop  = mm_readdatavalid && !empty;

   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_req
         assign req_waitrequest[gi]   = !(accept && (grant == gi[0]));
         assign req_readdatavalid[gi] = pop && (head == gi[0]);
      end
   endgenerate

   assign req0_waitrequest   = req_waitrequest[0];
   assign req1_waitrequest   = req_waitrequest[1];
   assign req0_readdatavalid = req_readdatavalid[0];
   assign req1_readdatavalid = req_readdatavalid[1];
   assign req0_readdata      = mm_readdata;
   assign req1_readdata      = mm_readdata;

   assign pending    = pending_reg;
   assign orphan_err = orphan_reg;

   // Lock lasts only as long as the command is stalled, so a dropped request frees it next cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         locked_reg     <= 1'b0;
         lock_id_reg    <= 1'b0;
         last_grant_reg <= 1'b1;
      end else begin
         locked_reg <= stall;
         if (stall) begin
            lock_id_reg <= grant;
         end
         if (accept) begin
            last_grant_reg <= grant;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_reg  <= '0;
         rd_ptr_reg  <= '0;
         pending_reg <= '0;
         orphan_reg  <= 1'b0;
      end else begin
         if (accept) begin
            wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
         end
         case ({accept, pop})
            2'b10:   pending_reg <= pending_reg + CNT_W'(1);
            2'b01:   pending_reg <= pending_reg - CNT_W'(1);
            default: pending_reg <= pending_reg;
         endcase
         if (mm_readdatavalid && empty) begin
            orphan_reg <= 1'b1;
         end
      end
   end

   // ID storage needs no reset: entries are only read behind a valid pending count.
   always_ff @(posedge clk) begin
      if (accept) begin
         id_mem[wr_ptr_reg] <= grant;
      end
   end

endmodule
